muldiv_unit: RTL and testbench

Iterative multiply/divide execution unit sitting directly downstream of the 32x32 register file's read ports and upstream of its write port. It takes the two read-port operands (rs, rt), computes MULT/MULTU/DIV/DIVU over multiple cycles into HI/LO, and presents a one-cycle write-back request (data, register number, enable) that connects straight to the register file write port.

---
 rtl/muldiv_pkg.sv | 12 +
 rtl/muldiv_neg.sv | 10 +
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and defaults for the iterative multiply/divide unit
package muldiv_pkg;
   localparam int WIDTH_DEFAULT = 32;
   typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
   function automatic logic op_is_signed(input logic [1:0] o);
      return o == OP_MULT || o == OP_DIV;
   endfunction
   function automatic logic op_is_div(input logic [1:0] o);
      return o == OP_DIV || o == OP_DIVU;
   endfunction
endpackage

// File: rtl/muldiv_neg.sv
// muldiv_neg: combinational conditional two's-complement negation
module muldiv_neg #(
   parameter int W = 32
) (
   input  logic [W-1:0] in,
   input  logic         neg,
   output logic [W-1:0] out
);
   assign out = neg ? -in : in;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO with regfile write-back; divider built only with MULDIV_DIV_EN
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       dst,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             we,
   output logic [4:0]       wn,
   output logic [WIDTH-1:0] wd,
   output logic             illegal
);
   localparam int CW = $clog2(WIDTH);
   state_e             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [4:0]         wn_q, wn_d;
   logic [WIDTH-1:0]   ua_q, ua_d, ub_q, ub_d, hi_q, hi_d, lo_q, lo_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               sa_q, sa_d, sb_q, sb_d, ill_q, ill_d;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [2*WIDTH-1:0] acc_mul, prod_fix;
   // operand magnitudes taken at accept so the datapath only ever works unsigned
   muldiv_neg #(.W(WIDTH)) u_neg_a (.in(a), .neg(op_is_signed(op) & a[WIDTH-1]), .out(abs_a));
   muldiv_neg #(.W(WIDTH)) u_neg_b (.in(b), .neg(op_is_signed(op) & b[WIDTH-1]), .out(abs_b));
   muldiv_neg #(.W(2*WIDTH)) u_neg_p (.in(acc_q), .neg(sa_q ^ sb_q), .out(prod_fix));
   // multiplier scans ub from its MSB, doubling the accumulator each step
   assign acc_mul = {acc_q[2*WIDTH-2:0], 1'b0} + (ub_q[WIDTH-1] ? {{WIDTH{1'b0}}, ua_q} : '0);
`ifdef MULDIV_DIV_EN
   logic               bz_q, bz_d, ge;
   logic [WIDTH:0]     rem_sh, diff;
   logic [WIDTH-1:0]   q_fix, r_fix;
   logic [2*WIDTH-1:0] acc_div;
   // restoring divide: remainder in acc high half, quotient bits shift into the low half
   assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], ua_q[WIDTH-1]};
   assign diff    = rem_sh - {1'b0, ub_q};
   assign ge      = ~diff[WIDTH];
   assign acc_div = {ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], ge};
   muldiv_neg #(.W(WIDTH)) u_neg_q (.in(acc_q[WIDTH-1:0]), .neg((sa_q ^ sb_q) & ~bz_q), .out(q_fix));
   muldiv_neg #(.W(WIDTH)) u_neg_r (.in(acc_q[2*WIDTH-1:WIDTH]), .neg(sa_q), .out(r_fix));
`endif
   assign busy    = state_q == CALC || state_q == FIX;
   assign done    = state_q == DONE;
   assign we      = done && !ill_q && wn_q != 5'd0;
   assign illegal = done && ill_q;
   assign wn      = wn_q;
   assign hi      = hi_q;
   assign lo      = lo_q;
   assign wd      = lo_q;
   // next-state: accept in IDLE/DONE, iterate in CALC, sign fix-up and result load in FIX
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      wn_d    = wn_q;
      ua_d    = ua_q;
      ub_d    = ub_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      ill_d   = ill_q;
`ifdef MULDIV_DIV_EN
      bz_d    = bz_q;
`endif
      case (state_q)
         CALC: begin
`ifdef MULDIV_DIV_EN
            acc_d = op_is_div(op_q) ? acc_div : acc_mul;
            ua_d  = op_is_div(op_q) ? {ua_q[WIDTH-2:0], 1'b0} : ua_q;
            ub_d  = op_is_div(op_q) ? ub_q : {ub_q[WIDTH-2:0], 1'b0};
`else
            acc_d = acc_mul;
            ub_d  = {ub_q[WIDTH-2:0], 1'b0};
`endif
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
         end
         FIX: begin
`ifdef MULDIV_DIV_EN
            {hi_d, lo_d} = op_is_div(op_q) ? {r_fix, q_fix} : prod_fix;
`else
            {hi_d, lo_d} = prod_fix;
`endif
            state_d = DONE;
         end
         default: begin
            if (start) begin
               op_d    = op;
               wn_d    = dst;
               ua_d    = abs_a;
               ub_d    = abs_b;
               sa_d    = op_is_signed(op) & a[WIDTH-1];
               sb_d    = op_is_signed(op) & b[WIDTH-1];
               acc_d   = '0;
               cnt_d   = '0;
               ill_d   = 1'b0;
               state_d = CALC;
`ifdef MULDIV_DIV_EN
               bz_d    = b == '0;
`else
               if (op_is_div(op)) begin
                  ill_d   = 1'b1;
                  state_d = DONE;
               end
`endif
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
      endcase
   end
   // state and datapath registers; reset discards any operation in flight
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= IDLE;
         op_q    <= '0;
         wn_q    <= '0;
         ua_q    <= '0;
         ub_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         wn_q    <= wn_d;
         ua_q    <= ua_d;
         ub_q    <= ub_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         ill_q   <= ill_d;
      end
   end
`ifdef MULDIV_DIV_EN
   // divide-by-zero flag, kept so the quotient stays all-ones regardless of signs
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) bz_q <= 1'b0;
      else bz_q <= bz_d;
   end
`endif
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
   import muldiv_pkg::*;
   logic        clk = 1'b0, clrn = 1'b0, start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0, b = '0;
   logic [4:0]  dst = '0;
   logic        busy, done, we, illegal;
   logic [31:0] hi, lo, wd;
   logic [4:0]  wn;
   int          errors = 0, checks = 0;
   logic [31:0] exp_hi = '0, exp_lo = '0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b), .dst(dst),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .we(we), .wn(wn), .wd(wd), .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] h, output logic [31:0] l);
      logic signed [63:0] sx, sy;
      logic [63:0] p;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      case (o)
         OP_MULT:  p = sx * sy;
         OP_MULTU: p = {32'd0, x} * {32'd0, y};
         OP_DIV: begin
            if (y == 0) p = {x, 32'hFFFFFFFF};
            else if (x == 32'h80000000 && y == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
            else p = {32'($signed(x) % $signed(y)), 32'($signed(x) / $signed(y))};
         end
         default: p = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      endcase
      {h, l} = p;
   endfunction

   task automatic wait_done(input int inj, output int n, output logic b1);
      n = 0;
      b1 = 1'b0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) b1 = busy;
         start = (n == inj);
         if (n == inj) begin
            op = OP_MULT;
            a = 32'd7;
            b = 32'd7;
         end else begin
            a = $urandom;
            b = $urandom;
         end
      end while (!done && n < 40);
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] d, input string tag);
      logic [31:0] eh, el;
      logic ill, b1;
      int n;
      model(o, x, y, eh, el);
      ill = 1'b0;
`ifndef MULDIV_DIV_EN
      if (o[1]) begin
         ill = 1'b1;
         eh = exp_hi;
         el = exp_lo;
      end
`endif
      op = o; a = x; b = y; dst = d; start = 1'b1;
      wait_done(0, n, b1);
      chk({tag, " latency"}, 64'(n), ill ? 64'd1 : 64'd34);
      chk({tag, " hi"}, {32'd0, hi}, {32'd0, eh});
      chk({tag, " lo"}, {32'd0, lo}, {32'd0, el});
      chk({tag, " we"}, {63'd0, we}, {63'd0, !ill && d != 0});
      chk({tag, " wn"}, {59'd0, wn}, {59'd0, d});
      chk({tag, " wd"}, {32'd0, wd}, {32'd0, el});
      chk({tag, " illegal"}, {63'd0, illegal}, {63'd0, ill});
      exp_hi = eh;
      exp_lo = el;
      @(negedge clk);
      chk({tag, " done pulse"}, {62'd0, done, we}, 64'd0);
   endtask

   initial begin
      int n, cnt;
      logic b1;
      logic [1:0] o;
      logic [31:0] x, y;
      repeat (2) @(negedge clk);
      chk("reset busy/done/we/ill", {60'd0, busy, done, we, illegal}, 64'd0);
      chk("reset hi/lo", {hi, lo}, 64'd0);
      chk("reset wd/wn", {27'd0, wd, wn}, 64'd0);
      clrn = 1'b1;
      @(negedge clk);
      run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, "multu max");
      run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, 5'd0, "mult -3*5");
      run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd7, "div -7/2");
      run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd8, "div overflow");
      run_op(OP_DIVU, 32'd100, 32'd0, 5'd9, "divu by zero");
      run_op(OP_MULT, 32'h80000000, 32'h80000000, 5'd31, "mult minneg");
      for (int i = 0; i < 24; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         case ($urandom_range(0, 4))
            0: y = 32'd0;
            1: y = 32'd1;
            2: y = 32'hFFFFFFFF;
            default: y = $urandom;
         endcase
         run_op(o, x, y, 5'($urandom_range(0, 31)), $sformatf("rand%0d op%0d", i, o));
      end
      op = OP_MULTU; a = 32'd3; b = 32'd4; dst = 5'd1; start = 1'b1;
      wait_done(10, n, b1);
      chk("ignored start latency", 64'(n), 64'd34);
      chk("ignored start busy", {63'd0, b1}, 64'd1);
      chk("ignored start lo", {32'd0, lo}, 64'd12);
      chk("ignored start hi", {32'd0, hi}, 64'd0);
      op = OP_MULT; a = 32'd7; b = 32'd7; dst = 5'd2; start = 1'b1;
      wait_done(0, n, b1);
      chk("b2b busy", {63'd0, b1}, 64'd1);
      chk("b2b latency", 64'(n), 64'd34);
      chk("b2b lo", {32'd0, lo}, 64'd49);
      chk("b2b we/wn", {58'd0, we, wn}, {58'd0, 1'b1, 5'd2});
      @(negedge clk);
      op = OP_MULTU; a = 32'h12345678; b = 32'h9ABCDEF0; dst = 5'd3; start = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      clrn = 1'b0;
      #1;
      chk("midcalc reset flags", {60'd0, busy, done, we, illegal}, 64'd0);
      chk("midcalc reset hi/lo", {hi, lo}, 64'd0);
      chk("midcalc reset wd/wn", {27'd0, wd, wn}, 64'd0);
      exp_hi = '0;
      exp_lo = '0;
      @(negedge clk);
      clrn = 1'b1;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cnt += int'(done);
      end
      chk("no done after reset", 64'(cnt), 64'd0);
      run_op(OP_MULT, 32'hFFFFFFFF, 32'd9, 5'd4, "post reset mult");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
